// File: rtl/csr_arb_pkg.sv
// csr_arb_pkg: shared encodings for the CSR port arbiter and its round-robin grant.
package csr_arb_pkg;
`ifdef RV64I
  localparam int DataSizeDefault = 64;
`else
  localparam int DataSizeDefault = 32;
`endif
  typedef enum logic [1:0] {CsrOpRead = 2'b00, CsrOpWrite = 2'b01, CsrOpSet = 2'b10, CsrOpClear = 2'b11} csr_op_e;
  typedef enum logic [1:0] {Idle, Read, Write, Resp} arb_state_e;
  localparam logic ReqCore = 1'b0;
  localparam logic ReqDebug = 1'b1;
  function automatic logic [1:0] owner_onehot(input logic id);
    return (id == ReqDebug) ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-input round-robin grant; the last winner yields on a tie, updated on accept.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);
  logic last_q, last_d;
  always_comb begin
    gnt_o = &req_i ? (last_q ? 2'b01 : 2'b10) : req_i;
    last_d = accept_i ? gnt_o[1] : last_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) last_q <= 1'b1;
    else last_q <= last_d;
  end
endmodule

// File: rtl/csr_port_arbiter.sv
// csr_port_arbiter: shares the CSR port between core and debug, running each request as an atomic read-modify-write.
module csr_port_arbiter
  import csr_arb_pkg::*;
#(
  parameter int DATA_SIZE = DataSizeDefault
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0]           req_op0,
  input  logic [1:0]           req_op1,
  input  logic [11:0]          req_addr0,
  input  logic [11:0]          req_addr1,
  input  logic [DATA_SIZE-1:0] req_wdata0,
  input  logic [DATA_SIZE-1:0] req_wdata1,
  output logic [1:0]           resp_valid,
  output logic [DATA_SIZE-1:0] resp_rdata,
  input  logic                 csr_busy,
  output logic                 csr_wr_en,
  output logic [11:0]          csr_addr,
  output logic [DATA_SIZE-1:0] csr_wr_data,
  input  logic [DATA_SIZE-1:0] csr_rd_data
);
  arb_state_e state_q, state_d;
  csr_op_e op_q, op_d;
  logic [11:0] addr_q, addr_d;
  logic [DATA_SIZE-1:0] wdata_q, wdata_d, old_q, old_d, rmw;
  logic owner_q, owner_d, hs;
  logic [1:0] gnt;
  rr_arbiter2 u_rr (
    .clk_i   (clock),
    .rst_i   (reset),
    .req_i   (req_valid),
    .accept_i(hs),
    .gnt_o   (gnt)
  );
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    owner_d = owner_q;
    old_d = old_q;
    req_ready = 2'b00;
    resp_valid = 2'b00;
    resp_rdata = '0;
    csr_wr_en = 1'b0;
    csr_addr = '0;
    csr_wr_data = '0;
    hs = 1'b0;
    rmw = (op_q == CsrOpSet) ? (old_q | wdata_q) : (op_q == CsrOpClear) ? (old_q & ~wdata_q) : wdata_q;
    case (state_q)
      Idle: begin
        req_ready = gnt & {2{~csr_busy}};
        hs = |req_ready;
        if (hs) begin
          owner_d = gnt[1];
          op_d = csr_op_e'(gnt[1] ? req_op1 : req_op0);
          addr_d = gnt[1] ? req_addr1 : req_addr0;
          wdata_d = gnt[1] ? req_wdata1 : req_wdata0;
          state_d = Read;
        end
      end
      Read: begin
        csr_addr = addr_q;
        old_d = csr_rd_data;
        // SET/CLEAR with an empty mask would rewrite the same value, so skip the write
        state_d = (op_q == CsrOpRead || (op_q != CsrOpWrite && wdata_q == '0)) ? Resp : Write;
      end
      Write: begin
        csr_addr = addr_q;
        csr_wr_data = rmw;
        csr_wr_en = ~csr_busy;
        state_d = csr_busy ? Write : Resp;
      end
      Resp: begin
        resp_valid = owner_onehot(owner_q);
        resp_rdata = old_q;
        state_d = Idle;
      end
      default: state_d = Idle;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= Idle;
      op_q <= CsrOpRead;
      addr_q <= '0;
      wdata_q <= '0;
      owner_q <= ReqCore;
      old_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      owner_q <= owner_d;
      old_q <= old_d;
    end
  end
endmodule
